// File: rtl/s3g_rx.sv
// s3g_rx: parses the 0xD5/length/payload/CRC-8 byte stream into a held payload buffer.
module s3g_rx #(
  parameter int MAX_PAYLOAD    = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_done,
  input  logic                     packet_ack,
  output logic                     packet_valid,
  output logic [7:0]               payload_len,
  output logic [8*MAX_PAYLOAD-1:0] payload,
  output logic                     busy,
  output logic                     error_strobe,
  output logic [2:0]               error_code
);
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CRC, S_HOLD} state_t;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] MAXP = 8'(MAX_PAYLOAD);
  localparam logic [7:0] SOP = 8'hD5;
  // CRC-8, polynomial x^8+x^2+x+1, data MSB first
  function automatic logic [7:0] next_crc8(input logic [7:0] d, input logic [7:0] c);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction
  state_t state_q, state_d;
  logic [7:0] crc_q, crc_d, cnt_q, cnt_d, len_q, len_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [8*MAX_PAYLOAD-1:0] pay_q, pay_d;
  logic valid_q, valid_d, busy_q, busy_d, estb_q, estb_d;
  logic [2:0] ecode_q, ecode_d;
  logic tmo_hit;
  assign tmo_hit = !rx_done && tmo_q == TMAX;
  always_comb begin
    state_d = state_q;
    crc_d = crc_q;
    cnt_d = cnt_q;
    len_d = len_q;
    pay_d = pay_q;
    valid_d = valid_q;
    busy_d = busy_q;
    estb_d = 1'b0;
    ecode_d = ecode_q;
    case (state_q)
      S_IDLE: if (rx_done && rx_data == SOP) begin
        state_d = S_LEN;
        busy_d = 1'b1;
      end
      S_LEN: if (rx_done) begin
        len_d = rx_data;
        crc_d = 8'h00;
        cnt_d = 8'h00;
        state_d = rx_data > MAXP ? S_IDLE : rx_data == 8'h00 ? S_CRC : S_DATA;
        busy_d = rx_data <= MAXP;
        estb_d = rx_data > MAXP;
        ecode_d = rx_data > MAXP ? 3'd1 : ecode_q;
      end else if (tmo_hit) begin
        state_d = S_IDLE;
        busy_d = 1'b0;
        estb_d = 1'b1;
        ecode_d = 3'd3;
      end
      S_DATA: if (rx_done) begin
        pay_d[int'(cnt_q)*8 +: 8] = rx_data;
        crc_d = next_crc8(rx_data, crc_q);
        cnt_d = cnt_q + 8'd1;
        state_d = (cnt_q + 8'd1 == len_q) ? S_CRC : S_DATA;
      end else if (tmo_hit) begin
        state_d = S_IDLE;
        busy_d = 1'b0;
        estb_d = 1'b1;
        ecode_d = 3'd3;
      end
      S_CRC: if (rx_done) begin
        busy_d = 1'b0;
        valid_d = rx_data == crc_q;
        state_d = rx_data == crc_q ? S_HOLD : S_IDLE;
        estb_d = rx_data != crc_q;
        ecode_d = rx_data != crc_q ? 3'd2 : ecode_q;
      end else if (tmo_hit) begin
        state_d = S_IDLE;
        busy_d = 1'b0;
        estb_d = 1'b1;
        ecode_d = 3'd3;
      end
      S_HOLD: if (packet_ack) begin
        // ack frees the buffer and the same-cycle byte is judged as if idle
        valid_d = 1'b0;
        state_d = (rx_done && rx_data == SOP) ? S_LEN : S_IDLE;
        busy_d = rx_done && rx_data == SOP;
      end else if (rx_done) begin
        estb_d = 1'b1;
        ecode_d = 3'd4;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        busy_d = 1'b0;
      end
    endcase
    tmo_d = (rx_done || state_d == S_IDLE) ? '0 :
            ((state_q == S_LEN || state_q == S_DATA || state_q == S_CRC) && tmo_q != TMAX) ? tmo_q + 1'b1 : tmo_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      crc_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      tmo_q <= '0;
      pay_q <= '0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      estb_q <= 1'b0;
      ecode_q <= '0;
    end else begin
      state_q <= state_d;
      crc_q <= crc_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      tmo_q <= tmo_d;
      pay_q <= pay_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
      estb_q <= estb_d;
      ecode_q <= ecode_d;
    end
  end
  assign packet_valid = valid_q;
  assign payload_len = len_q;
  assign payload = pay_q;
  assign busy = busy_q;
  assign error_strobe = estb_q;
  assign error_code = ecode_q;
endmodule

// File: tb/tb_s3g_rx.sv
// tb_s3g_rx: directed-vector bench for the S3G packet receiver.
module tb_s3g_rx;
  logic clk = 1'b0, rst = 1'b1, rx_done = 1'b0, packet_ack = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic packet_valid, busy, error_strobe;
  logic [7:0] payload_len;
  logic [127:0] payload;
  logic [2:0] error_code;
  int checks = 0, failures = 0;
  s3g_rx #(.MAX_PAYLOAD(16), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .packet_ack(packet_ack),
    .packet_valid(packet_valid), .payload_len(payload_len), .payload(payload), .busy(busy),
    .error_strobe(error_strobe), .error_code(error_code)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // called at a falling edge; the byte is consumed by the next rising edge
  task automatic send(input logic [7:0] b);
    rx_done = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_done = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic ack();
    packet_ack = 1'b1;
    @(negedge clk);
    packet_ack = 1'b0;
  endtask
  initial begin
    idle(2);
    chk("rst_valid", packet_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_strobe", error_strobe, 0);
    chk("rst_code", error_code, 0);
    chk("rst_len", payload_len, 0);
    chk("rst_payload", payload, 0);
    rst = 1'b0;
    idle(1);
    send(8'hD5);
    chk("t1_busy", busy, 1);
    send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'hD4);
    chk("t1_valid", packet_valid, 1);
    chk("t1_len", payload_len, 3);
    chk("t1_payload", payload[23:0], 24'h332211);
    chk("t1_busy_done", busy, 0);
    idle(3);
    chk("t1_hold", packet_valid, 1);
    ack();
    chk("t1_acked", packet_valid, 0);
    send(8'hD5); send(8'h00); send(8'h00);
    chk("t2_zero_valid", packet_valid, 1);
    chk("t2_zero_len", payload_len, 0);
    ack();
    send(8'hD5); send(8'h00); send(8'h5A);
    chk("t2_crc_strobe", error_strobe, 1);
    chk("t2_crc_code", error_code, 2);
    chk("t2_crc_valid", packet_valid, 0);
    idle(1);
    chk("t2_strobe_pulse", error_strobe, 0);
    send(8'hD5); send(8'h11);
    chk("t3_len_strobe", error_strobe, 1);
    chk("t3_len_code", error_code, 1);
    chk("t3_len_busy", busy, 0);
    send(8'hD5); send(8'h01); send(8'hAA); send(8'h5F);
    chk("t3_next_valid", packet_valid, 1);
    chk("t3_next_payload", payload[7:0], 8'hAA);
    ack();
    send(8'hD5); send(8'h02); send(8'hAA);
    idle(99);
    chk("t4_pre_busy", busy, 1);
    chk("t4_pre_strobe", error_strobe, 0);
    idle(1);
    chk("t4_tmo_strobe", error_strobe, 1);
    chk("t4_tmo_code", error_code, 3);
    chk("t4_tmo_busy", busy, 0);
    send(8'hD5); send(8'h02); send(8'hAA);
    idle(98);
    send(8'hBB);
    idle(98);
    send(8'hB2);
    chk("t4_late_valid", packet_valid, 1);
    chk("t4_late_payload", payload[15:0], 16'hBBAA);
    chk("t4_late_code", error_code, 3);
    ack();
    send(8'hD5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'hD4);
    send(8'h40);
    chk("t5_ovr_strobe", error_strobe, 1);
    chk("t5_ovr_code", error_code, 4);
    chk("t5_ovr_valid", packet_valid, 1);
    chk("t5_ovr_payload", payload[23:0], 24'h332211);
    packet_ack = 1'b1;
    rx_done = 1'b1;
    rx_data = 8'hD5;
    @(negedge clk);
    packet_ack = 1'b0;
    rx_done = 1'b0;
    chk("t5_ack_valid", packet_valid, 0);
    chk("t5_ack_busy", busy, 1);
    chk("t5_ack_strobe", error_strobe, 0);
    send(8'h01); send(8'hAA); send(8'h5F);
    chk("t5_next_valid", packet_valid, 1);
    ack();
    send(8'hD5); send(8'h03); send(8'h11);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_code", error_code, 0);
    chk("t6_rst_payload", payload, 0);
    chk("t6_rst_len", payload_len, 0);
    send(8'h00); send(8'hFF); send(8'hD4);
    chk("t6_junk_busy", busy, 0);
    chk("t6_junk_strobe", error_strobe, 0);
    send(8'hD5); send(8'h02); send(8'h01); send(8'h02); send(8'h1B);
    chk("t6_valid", packet_valid, 1);
    chk("t6_len", payload_len, 2);
    chk("t6_payload", payload, 128'h0201);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
